// File: rtl/serial_paralelo_sync_if.sv
// Serial line in, assembled parallel words out, for the comma-aligned receiver.
interface serial_paralelo_sync_if #(
    parameter int unsigned WIDTH = 8
);
    logic             data_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             word_tick;
    logic             sync_ok;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  word_tick,
        input  sync_ok
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output word_tick,
        output sync_ok
    );
endinterface

// File: rtl/serial_paralelo_sync.sv
// Serial-to-parallel receiver: hunts a comma at any bit offset, locks after
// SYNC_COUNT aligned commas, then emits WIDTH-bit words until the comma gap runs out.
module serial_paralelo_sync #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
    parameter int unsigned      SYNC_COUNT = 4,
    parameter int unsigned      MAX_GAP    = 16
) (
    input logic                  clk_32f,
    input logic                  reset,
    serial_paralelo_sync_if.slave bus
);
    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(SYNC_COUNT + 1);
    localparam int unsigned GAP_W = (MAX_GAP == 0) ? 1 : $clog2(MAX_GAP + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [BIT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] comma_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             tick_q;
    logic             sync_q;

    logic [WIDTH-1:0] nxt_c;
    logic             is_comma_c;
    logic             boundary_c;
    logic             gap_full_c;

    // Word decisions look at the shift register including the bit sampled this edge.
    assign nxt_c      = {sr[WIDTH-2:0], bus.data_in};
    assign is_comma_c = (nxt_c == COMMA);
    assign boundary_c = (bit_cnt == BIT_W'(WIDTH - 1));
    assign gap_full_c = (MAX_GAP != 0) && (gap_cnt == GAP_W'(MAX_GAP));

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            sr        <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            gap_cnt   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            tick_q    <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            sr      <= nxt_c;
            valid_q <= 1'b0;
            tick_q  <= 1'b0;
            unique case (state)
                HUNT: begin
                    if (is_comma_c) begin
                        bit_cnt   <= '0;
                        comma_cnt <= CNT_W'(1);
                        gap_cnt   <= '0;
                        if (SYNC_COUNT == 1) begin
                            state  <= LOCKED;
                            sync_q <= 1'b1;
                        end else begin
                            state <= ALIGN;
                        end
                    end
                end
                ALIGN: begin
                    bit_cnt <= boundary_c ? '0 : bit_cnt + BIT_W'(1);
                    if (boundary_c) begin
                        if (is_comma_c) begin
                            comma_cnt <= comma_cnt + CNT_W'(1);
                            if (comma_cnt == CNT_W'(SYNC_COUNT - 1)) begin
                                state   <= LOCKED;
                                sync_q  <= 1'b1;
                                gap_cnt <= '0;
                            end
                        end else begin
                            state     <= HUNT;
                            comma_cnt <= '0;
                        end
                    end
                end
                LOCKED: begin
                    bit_cnt <= boundary_c ? '0 : bit_cnt + BIT_W'(1);
                    if (boundary_c) begin
                        if (is_comma_c) begin
                            tick_q  <= 1'b1;
                            data_q  <= nxt_c;
                            gap_cnt <= '0;
                        end else if (gap_full_c) begin
                            // Too long without a comma: drop this word and re-hunt.
                            state     <= HUNT;
                            sync_q    <= 1'b0;
                            comma_cnt <= '0;
                            gap_cnt   <= '0;
                        end else begin
                            tick_q  <= 1'b1;
                            valid_q <= 1'b1;
                            data_q  <= nxt_c;
                            if (MAX_GAP != 0) gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= HUNT;
                    sync_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.word_tick = tick_q;
    assign bus.sync_ok   = sync_q;
endmodule
